// File: rtl/tis_row.sv
// rtl/tis_row.sv - row of four TIS-100-style nodes with blocking LEFT/RIGHT mailboxes
// Optional 7-segment decode of acc[0]/acc[1] on hex when TIS_ROW_HEX_EN is defined.
module tis_row #(
    parameter int NODES = 4,
    parameter int SLOTS = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         p_length     [NODES],
    input  logic [15:0]        prog         [NODES*SLOTS],
    input  logic signed [10:0] up_data      [NODES],
    input  logic signed [10:0] down_data    [NODES],
    input  logic [NODES-1:0]   wready_up,
    input  logic [NODES-1:0]   wready_down,
    output logic [NODES-1:0]   up_rack,
    output logic [NODES-1:0]   down_rack,
    output logic signed [10:0] up_out       [NODES],
    output logic signed [10:0] down_out     [NODES],
    output logic [NODES-1:0]   up_out_stb,
    output logic [NODES-1:0]   down_out_stb,
    output logic signed [10:0] acc          [NODES],
    output logic [3:0]         pc           [NODES]
`ifdef TIS_ROW_HEX_EN
    ,
    output logic [6:0]         hex          [4]
`endif
);

    localparam logic [3:0] OP_NOP = 4'd0, OP_MOV = 4'd1, OP_MOVI = 4'd2, OP_SWP = 4'd3;
    localparam logic [3:0] OP_SAV = 4'd4, OP_ADD = 4'd5, OP_ADDI = 4'd6, OP_SUB = 4'd7;
    localparam logic [3:0] OP_SUBI = 4'd8, OP_NEG = 4'd9, OP_JMP = 4'd10, OP_JEZ = 4'd11;
    localparam logic [3:0] OP_JNZ = 4'd12, OP_JGZ = 4'd13, OP_JLZ = 4'd14, OP_JRO = 4'd15;
    localparam logic [2:0] S_ACC = 3'd1, S_LEFT = 3'd2, S_RIGHT = 3'd3, S_UP = 3'd4, S_DOWN = 3'd5;

    // Mailboxes are indexed by boundary b (between node b-1 and node b); b=0 and b=NODES are row edges.
    logic               mr_v [NODES+1];
    logic signed [10:0] mr_d [NODES+1];
    logic               ml_v [NODES+1];
    logic signed [10:0] ml_d [NODES+1];
    logic               fill_mr [NODES+1], fill_ml [NODES+1];
    logic signed [10:0] mr_fd [NODES+1], ml_fd [NODES+1];
    logic               take_mr [NODES+1], take_ml [NODES+1];

    logic signed [10:0] bak [NODES], hval [NODES];
    logic               hv [NODES], pend [NODES];
    logic [15:0]        inst [NODES];
    logic               src_port [NODES], rd_ok [NODES], cons [NODES];
    logic signed [10:0] rd_val [NODES];
    logic [NODES-1:0]   up_take, down_take;

    logic signed [10:0] acc_n [NODES], bak_n [NODES], hval_n [NODES];
    logic signed [10:0] up_n [NODES], dn_n [NODES];
    logic [3:0]         pc_n [NODES];
    logic               hv_n [NODES], pend_n [NODES];
    logic [NODES-1:0]   ustb_n, dstb_n;

    function automatic logic signed [10:0] sat(input logic signed [12:0] x);
        if (x > 13'sd999)       return 11'sd999;
        else if (x < -13'sd999) return -11'sd999;
        else                    return x[10:0];
    endfunction

    function automatic logic is_port(input logic [2:0] s);
        return (s >= S_LEFT) && (s <= S_DOWN);
    endfunction

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            inst[i] = prog[6'(i*SLOTS) + 6'(pc[i])];
        end
    end

    // Read side depends only on registered state, so writers can use it to see consumption.
    always_comb begin
        for (int b = 0; b <= NODES; b++) begin
            take_mr[b] = 1'b0;
            take_ml[b] = 1'b0;
        end
        up_take   = '0;
        down_take = '0;
        for (int i = 0; i < NODES; i++) begin
            rd_ok[i]  = 1'b0;
            rd_val[i] = '0;
            case (inst[i][11:9])
                S_LEFT:  begin rd_ok[i] = mr_v[i];       rd_val[i] = mr_d[i];       end
                S_RIGHT: begin rd_ok[i] = ml_v[i+1];     rd_val[i] = ml_d[i+1];     end
                S_UP:    begin rd_ok[i] = wready_up[i];   rd_val[i] = up_data[i];   end
                S_DOWN:  begin rd_ok[i] = wready_down[i]; rd_val[i] = down_data[i]; end
                default: ;
            endcase
            src_port[i] = (inst[i][15:12] == OP_MOV || inst[i][15:12] == OP_ADD ||
                           inst[i][15:12] == OP_SUB || inst[i][15:12] == OP_JRO) &&
                          is_port(inst[i][11:9]);
            cons[i] = src_port[i] && !hv[i] && (p_length[i] != 4'd0) && rd_ok[i];
            if (cons[i]) begin
                case (inst[i][11:9])
                    S_LEFT:  take_mr[i]   = 1'b1;
                    S_RIGHT: take_ml[i+1] = 1'b1;
                    S_UP:    up_take[i]   = 1'b1;
                    default: down_take[i] = 1'b1;
                endcase
            end
        end
    end

    assign up_rack   = up_take & {NODES{~rst}};
    assign down_rack = down_take & {NODES{~rst}};

    logic [3:0]         op, nxt, tgt, jt, lim4;
    logic [2:0]         dsel;
    logic signed [10:0] val;
    logic signed [12:0] a13, v13, i13, t13, l13;
    logic               have, adv, jmp;

    always_comb begin
        for (int b = 0; b <= NODES; b++) begin
            fill_mr[b] = 1'b0;
            fill_ml[b] = 1'b0;
            mr_fd[b]   = '0;
            ml_fd[b]   = '0;
        end
        ustb_n = '0;
        dstb_n = '0;
        op = '0; nxt = '0; tgt = '0; jt = '0; lim4 = '0; dsel = '0; val = '0;
        a13 = '0; v13 = '0; i13 = '0; t13 = '0; l13 = '0; have = 1'b0; adv = 1'b0; jmp = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            acc_n[i]  = acc[i];
            bak_n[i]  = bak[i];
            pc_n[i]   = pc[i];
            hv_n[i]   = hv[i];
            hval_n[i] = hval[i];
            pend_n[i] = pend[i];
            up_n[i]   = up_out[i];
            dn_n[i]   = down_out[i];
            op   = inst[i][15:12];
            dsel = (op == OP_MOVI) ? inst[i][11:9] : inst[i][8:6];
            lim4 = p_length[i] - 4'd1;
            nxt  = (pc[i] >= lim4) ? 4'd0 : pc[i] + 4'd1;
            tgt  = inst[i][3:0];
            jt   = (tgt >= p_length[i]) ? 4'd0 : tgt;
            if (op == OP_MOVI)             val = {{2{inst[i][8]}}, inst[i][8:0]};
            else if (src_port[i])          val = hv[i] ? hval[i] : rd_val[i];
            else if (inst[i][11:9] == S_ACC) val = acc[i];
            else                           val = '0;
            have = !src_port[i] || hv[i] || cons[i];
            a13  = {{2{acc[i][10]}}, acc[i]};
            v13  = {{2{val[10]}}, val};
            i13  = {{2{inst[i][10]}}, inst[i][10:0]};
            t13  = $signed({9'd0, pc[i]}) + v13;
            l13  = $signed({9'd0, lim4});
            adv  = 1'b0;
            jmp  = 1'b0;
            if (p_length[i] == 4'd0) begin
                pc_n[i]   = 4'd0;
                hv_n[i]   = 1'b0;
                pend_n[i] = 1'b0;
            end else if (op == OP_MOV && cons[i] && is_port(dsel)) begin
                // port-to-port move: park the value, write phase runs next cycle
                hv_n[i]   = 1'b1;
                hval_n[i] = rd_val[i];
            end else if (have) begin
                case (op)
                    OP_MOV, OP_MOVI: begin
                        case (dsel)
                            S_ACC:  begin acc_n[i] = val; adv = 1'b1; end
                            S_UP:   begin up_n[i] = val; ustb_n[i] = 1'b1; adv = 1'b1; end
                            S_DOWN: begin dn_n[i] = val; dstb_n[i] = 1'b1; adv = 1'b1; end
                            S_LEFT: begin
                                if (i != 0) begin
                                    if (!pend[i]) begin
                                        fill_ml[i] = 1'b1;
                                        ml_fd[i]   = val;
                                        pend_n[i]  = 1'b1;
                                    end else if (take_ml[i]) begin
                                        pend_n[i] = 1'b0;
                                        adv       = 1'b1;
                                    end
                                end
                            end
                            S_RIGHT: begin
                                if (i != NODES-1) begin
                                    if (!pend[i]) begin
                                        fill_mr[i+1] = 1'b1;
                                        mr_fd[i+1]   = val;
                                        pend_n[i]    = 1'b1;
                                    end else if (take_mr[i+1]) begin
                                        pend_n[i] = 1'b0;
                                        adv       = 1'b1;
                                    end
                                end
                            end
                            default: adv = 1'b1;
                        endcase
                    end
                    OP_SWP:  begin acc_n[i] = bak[i]; bak_n[i] = acc[i]; adv = 1'b1; end
                    OP_SAV:  begin bak_n[i] = acc[i]; adv = 1'b1; end
                    OP_ADD:  begin acc_n[i] = sat(a13 + v13); adv = 1'b1; end
                    OP_SUB:  begin acc_n[i] = sat(a13 - v13); adv = 1'b1; end
                    OP_ADDI: begin acc_n[i] = sat(a13 + i13); adv = 1'b1; end
                    OP_SUBI: begin acc_n[i] = sat(a13 - i13); adv = 1'b1; end
                    OP_NEG:  begin acc_n[i] = sat(13'sd0 - a13); adv = 1'b1; end
                    OP_JMP:  begin jmp = 1'b1; adv = 1'b1; end
                    OP_JEZ:  begin jmp = (acc[i] == 11'sd0); adv = 1'b1; end
                    OP_JNZ:  begin jmp = (acc[i] != 11'sd0); adv = 1'b1; end
                    OP_JGZ:  begin jmp = (acc[i] > 11'sd0); adv = 1'b1; end
                    OP_JLZ:  begin jmp = (acc[i] < 11'sd0); adv = 1'b1; end
                    default: adv = 1'b1;
                endcase
                if (adv) begin
                    hv_n[i] = 1'b0;
                    if (op == OP_JRO)
                        pc_n[i] = (t13 < 13'sd0) ? 4'd0 : (t13 > l13) ? lim4 : t13[3:0];
                    else
                        pc_n[i] = jmp ? jt : nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) begin
                acc[i]      <= '0;
                bak[i]      <= '0;
                pc[i]       <= '0;
                hv[i]       <= 1'b0;
                hval[i]     <= '0;
                pend[i]     <= 1'b0;
                up_out[i]   <= '0;
                down_out[i] <= '0;
            end
            for (int b = 0; b <= NODES; b++) begin
                mr_v[b] <= 1'b0;
                mr_d[b] <= '0;
                ml_v[b] <= 1'b0;
                ml_d[b] <= '0;
            end
            up_out_stb   <= '0;
            down_out_stb <= '0;
        end else begin
            acc          <= acc_n;
            bak          <= bak_n;
            pc           <= pc_n;
            hv           <= hv_n;
            hval         <= hval_n;
            pend         <= pend_n;
            up_out       <= up_n;
            down_out     <= dn_n;
            up_out_stb   <= ustb_n;
            down_out_stb <= dstb_n;
            for (int b = 0; b <= NODES; b++) begin
                if (fill_mr[b]) begin
                    mr_v[b] <= 1'b1;
                    mr_d[b] <= mr_fd[b];
                end else if (take_mr[b]) begin
                    mr_v[b] <= 1'b0;
                end
                if (fill_ml[b]) begin
                    ml_v[b] <= 1'b1;
                    ml_d[b] <= ml_fd[b];
                end else if (take_ml[b]) begin
                    ml_v[b] <= 1'b0;
                end
            end
        end
    end

`ifdef TIS_ROW_HEX_EN
    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign hex[3] = seg(acc[1][7:4]);
    assign hex[2] = seg(acc[1][3:0]);
    assign hex[1] = seg(acc[0][7:4]);
    assign hex[0] = seg(acc[0][3:0]);
`endif

endmodule

// File: tb/tb_tis_row.sv
// tb/tb_tis_row.sv - directed and random checks of tis_row against an instruction-level model
module tb_tis_row;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         p_length     [4];
    logic [15:0]        prog         [60];
    logic signed [10:0] up_data      [4];
    logic signed [10:0] down_data    [4];
    logic [3:0]         wready_up, wready_down;
    logic [3:0]         up_rack, down_rack, up_out_stb, down_out_stb;
    logic signed [10:0] up_out [4], down_out [4], acc [4];
    logic [3:0]         pc [4];
`ifdef TIS_ROW_HEX_EN
    logic [6:0]         hex [4];
`endif

    int errors = 0;
    int checks = 0;
    int m_acc, m_bak, m_pc;

    tis_row dut (
        .clk(clk), .rst(rst), .p_length(p_length), .prog(prog),
        .up_data(up_data), .down_data(down_data),
        .wready_up(wready_up), .wready_down(wready_down),
        .up_rack(up_rack), .down_rack(down_rack),
        .up_out(up_out), .down_out(down_out),
        .up_out_stb(up_out_stb), .down_out_stb(down_out_stb),
        .acc(acc), .pc(pc)
`ifdef TIS_ROW_HEX_EN
        , .hex(hex)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        for (int k = 0; k < 60; k++) prog[k] = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            p_length[k] = 4'd0; up_data[k] = '0; down_data[k] = '0;
        end
        wready_up = '0; wready_down = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
    endtask

    function automatic int sx(input int v, input int bits);
        return (v >= (1 << (bits-1))) ? v - (1 << bits) : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // One instruction of node 0, non-port operands only, in plain integer arithmetic.
    task automatic mstep(input int len);
        int w, op, s, d, v, nx, tg, t;
        w  = int'(prog[m_pc]);
        op = w >> 12; s = (w >> 9) & 7; d = (w >> 6) & 7;
        v  = (s == 1) ? m_acc : 0;
        nx = (m_pc >= len-1) ? 0 : m_pc + 1;
        tg = w & 15; if (tg >= len) tg = 0;
        case (op)
            1:  begin if (d == 1) m_acc = v; m_pc = nx; end
            2:  begin if (s == 1) m_acc = sx(w & 511, 9); m_pc = nx; end
            3:  begin t = m_acc; m_acc = m_bak; m_bak = t; m_pc = nx; end
            4:  begin m_bak = m_acc; m_pc = nx; end
            5:  begin m_acc = clampi(m_acc + v, -999, 999); m_pc = nx; end
            6:  begin m_acc = clampi(m_acc + sx(w & 2047, 11), -999, 999); m_pc = nx; end
            7:  begin m_acc = clampi(m_acc - v, -999, 999); m_pc = nx; end
            8:  begin m_acc = clampi(m_acc - sx(w & 2047, 11), -999, 999); m_pc = nx; end
            9:  begin m_acc = clampi(-m_acc, -999, 999); m_pc = nx; end
            10: m_pc = tg;
            11: m_pc = (m_acc == 0) ? tg : nx;
            12: m_pc = (m_acc != 0) ? tg : nx;
            13: m_pc = (m_acc > 0) ? tg : nx;
            14: m_pc = (m_acc < 0) ? tg : nx;
            15: m_pc = clampi(m_pc + v, 0, len-1);
            default: m_pc = nx;
        endcase
    endtask

    function automatic logic [15:0] gen_inst();
        int op, s, d;
        int codes [4] = '{0, 1, 6, 7};
        op = $urandom_range(0, 15);
        s  = codes[$urandom_range(0, 3)];
        d  = codes[$urandom_range(0, 3)];
        case (op)
            1:             return 16'((op << 12) | (s << 9) | (d << 6));
            2:             return 16'((op << 12) | (s << 9) | $urandom_range(0, 511));
            5, 7, 15:      return 16'((op << 12) | (s << 9));
            6, 8:          return 16'((op << 12) | $urandom_range(0, 2047));
            10, 11, 12, 13, 14: return 16'((op << 12) | $urandom_range(0, 15));
            default:       return 16'(op << 12);
        endcase
    endfunction

    initial begin
        // ADDI 5 accumulates then saturates; also checks reset state
        clear_all();
        prog[0] = 16'h6005; p_length[0] = 4'd1;
        rst = 1'b1; tick(); tick();
        chk("reset_acc0", acc[0], 0);
        chk("reset_pc0", pc[0], 0);
        chk("reset_acc3", acc[3], 0);
        chk("reset_rack", int'(up_rack | down_rack), 0);
        chk("reset_stb", int'(up_out_stb | down_out_stb), 0);
        rst = 1'b0;
        tick(); chk("addi_1", acc[0], 5);
        tick(); chk("addi_2", acc[0], 10);
        tick(); chk("addi_3", acc[0], 15);
        for (int k = 0; k < 197; k++) tick();
        chk("addi_sat", acc[0], 999);
        tick(); chk("addi_sat_hold", acc[0], 999);

        // mailbox handoff node0 -> node1
        clear_all();
        prog[0] = 16'h2607; prog[1] = 16'h0000; p_length[0] = 4'd2;
        prog[15] = 16'h1440; p_length[1] = 4'd1;
        do_reset();
        tick();
        chk("mb_acc1_c1", acc[1], 0);
        chk("mb_pc0_stall", pc[0], 0);
        tick();
        chk("mb_acc1_c2", acc[1], 7);
        chk("mb_pc0_adv", pc[0], 1);

        // UP read stalls until wready
        clear_all();
        prog[15] = 16'h1840; prog[16] = 16'h0000; p_length[1] = 4'd2;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("up_pc_frozen", pc[1], 0);
            chk("up_no_rack", up_rack[1], 0);
        end
        up_data[1] = -11'sd3; wready_up[1] = 1'b1; #1;
        chk("up_rack_pulse", up_rack[1], 1);
        tick();
        wready_up[1] = 1'b0; #1;
        chk("up_acc", acc[1], -3);
        chk("up_pc_adv", pc[1], 1);
        chk("up_rack_off", up_rack[1], 0);

        // ADDI 1 / JNZ 0 loop
        clear_all();
        prog[0] = 16'h6001; prog[1] = 16'hC000; p_length[0] = 4'd2;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("jnz_pc", pc[0], k % 2);
            chk("jnz_acc", acc[0], (k + 1) / 2);
        end

        // JRO clamp and out-of-range jump target
        clear_all();
        prog[0] = 16'h2214; prog[1] = 16'hF200; prog[2] = 16'h0000; p_length[0] = 4'd3;
        prog[15] = 16'h0000; prog[16] = 16'hA009; prog[17] = 16'h0000; p_length[1] = 4'd3;
        do_reset();
        tick(); chk("jro_acc", acc[0], 20); chk("jmp_pc_c1", pc[1], 1);
        tick(); chk("jro_clamp", pc[0], 2); chk("jmp_oob", pc[1], 0);

        // node3 RIGHT write stalls forever; node2 DOWN write strobes
        clear_all();
        prog[45] = 16'h6004; prog[46] = 16'h12C0; prog[47] = 16'h0000; p_length[3] = 4'd3;
        prog[30] = 16'h2A05; prog[31] = 16'h0000; p_length[2] = 4'd2;
        do_reset();
        tick();
        chk("edge_acc", acc[3], 4);
        chk("down_val", down_out[2], 5);
        chk("down_stb", down_out_stb[2], 1);
        tick();
        chk("down_stb_off", down_out_stb[2], 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("edge_pc_stall", pc[3], 1);
        end
        chk("edge_acc_hold", acc[3], 4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("edge_rst_pc", pc[3], 0);
        chk("edge_rst_acc", acc[3], 0);

`ifdef TIS_ROW_HEX_EN
        clear_all();
        prog[0] = 16'h22A5; p_length[0] = 4'd1;
        do_reset();
        chk("hex0_zero", hex[0], 7'h40);
        tick();
        chk("hex1_A", hex[1], 7'h08);
        chk("hex0_5", hex[0], 7'h12);
        chk("hex3_zero", hex[3], 7'h40);
        chk("hex2_zero", hex[2], 7'h40);
`endif

        // random single-node programs vs model
        for (int t = 0; t < 6; t++) begin
            int len;
            clear_all();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) prog[k] = gen_inst();
            p_length[0] = 4'(len);
            do_reset();
            m_acc = 0; m_bak = 0; m_pc = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                mstep(len);
                chk("rnd_acc", acc[0], m_acc);
                chk("rnd_pc", pc[0], m_pc);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
